// File: rtl/cache_data_ram_pkg.sv
// cache_ram_pkg: shared types and limits for the cache data RAM slice.
package cache_ram_pkg;
    typedef enum logic {ST_CLEAR, ST_READY} state_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/cache_data_ram_if.sv
// cache_data_ram_if: request/response bundle between cache controller and data RAM.
interface cache_data_ram_if #(parameter int WIDTH = 32, parameter int ADDR_W = 4);
    logic                 clear_start;
    logic                 busy;
    logic                 req_ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [WIDTH/8-1:0]   wr_be;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rsp_valid;
    logic [WIDTH-1:0]     rsp_rdata;
    modport master (
        output clear_start, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  clear_start, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/cache_data_ram_rd_pipe.sv
// cache_ram_rd_pipe: LAT-deep valid/data shift stage; each stage's data only moves with a valid,
// so the output word holds its last value between pulses. Flushed by the active-low reset.
module cache_ram_rd_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [LAT-1:0]   vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [LAT];
    logic [WIDTH-1:0] dat_d [LAT];

    always_comb begin
        vld_d[0] = in_valid;
        dat_d[0] = in_valid ? in_data : dat_q[0];
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_data  = dat_q[LAT-1];
endmodule

// File: rtl/cache_data_ram.sv
// cache_data_ram: 1R1W byte-enabled cache data store with pipelined reads,
// selectable read-during-write result and a sequenced one-word-per-cycle clear.
module cache_data_ram
    import cache_ram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 4,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic               clk,
    input  logic               reset,
    cache_data_ram_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST = '1;

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("cache_data_ram: WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
        $error("cache_data_ram: READ_LATENCY must be 1 or 2");
    end

    logic [WIDTH-1:0]  mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy, wr_acc, rd_acc, mem_we, bypass;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata, merged, rd_word;
    logic [NB-1:0]     mem_wbe;

    always_comb begin
        busy      = state_q == ST_CLEAR;
        wr_acc    = bus.wr_en && !busy;
        rd_acc    = bus.rd_en && !busy;
        // The clear sequencer owns the write port while busy; nothing writes in a reset cycle.
        mem_we    = reset && (busy || wr_acc);
        mem_waddr = busy ? clr_ptr_q : bus.wr_addr;
        mem_wdata = busy ? '0 : bus.wr_data;
        mem_wbe   = busy ? '1 : bus.wr_be;
        merged    = mem_q[bus.rd_addr];
        for (int i = 0; i < NB; i++)
            if (bus.wr_be[i]) merged[8*i +: 8] = bus.wr_data[8*i +: 8];
        bypass    = WRITE_FIRST != 0 && wr_acc && bus.wr_addr == bus.rd_addr;
        rd_word   = bypass ? merged : mem_q[bus.rd_addr];
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (busy) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            state_d   = clr_ptr_q == LAST ? ST_READY : ST_CLEAR;
        end else if (bus.clear_start) begin
            clr_ptr_d = '0;
            state_d   = ST_CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < NB; i++)
                if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    assign bus.busy      = busy;
    assign bus.req_ready = !busy;

    cache_ram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LATENCY)) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (bus.rsp_valid),
        .out_data  (bus.rsp_rdata)
    );
endmodule

// File: tb/tb_cache_data_ram.sv
// tb_cache_data_ram: directed stimulus against an array/queue model checked every cycle,
// plus literal expectations on individual read responses.
module tb_cache_data_ram;
    localparam int L     = 2;
    localparam int WF    = 1;
    localparam int DEPTH = 16;

    typedef struct {
        int          c;
        logic [31:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    cache_data_ram_if #(.WIDTH(32), .ADDR_W(4)) bus ();

    cache_data_ram #(.WIDTH(32), .ADDR_W(4), .READ_LATENCY(L), .WRITE_FIRST(WF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    bit          started = 0;
    bit          exp_valid = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] m [DEPTH];
    rsp_t        pend [$];
    rsp_t        got [$];

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h cycle=%0d", n, a, e, cyc);
        end
    endtask

    // Model: a clear empties the array at once and keeps the RAM busy for DEPTH cycles.
    always @(posedge clk) begin : model
        logic [31:0] w;
        cyc++;
        if (!reset) begin
            busy_cnt = DEPTH;
            pend.delete();
            exp_valid = 0;
            exp_rdata = '0;
            foreach (m[i]) m[i] = '0;
            started = 1;
        end else begin
            if (busy_cnt != 0) busy_cnt--;
            else begin
                if (bus.rd_en) begin
                    w = m[bus.rd_addr];
                    if (WF != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr)
                        w = merge(w, bus.wr_data, bus.wr_be);
                    pend.push_back('{cyc + L - 1, w});
                end
                if (bus.wr_en) m[bus.wr_addr] = merge(m[bus.wr_addr], bus.wr_data, bus.wr_be);
                if (bus.clear_start) begin
                    busy_cnt = DEPTH;
                    foreach (m[i]) m[i] = '0;
                end
            end
            exp_valid = pend.size() != 0 && pend[0].c == cyc;
            if (exp_valid) exp_rdata = pend.pop_front().d;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(bus.busy), 32'(busy_cnt != 0));
            chk("req_ready", 32'(bus.req_ready), 32'(busy_cnt == 0));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
            if (bus.rsp_valid) got.push_back('{cyc, bus.rsp_rdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
        tick();
        bus.wr_en = 0;
    endtask

    task automatic burst(input int n, input logic [3:0] a [16], input logic [31:0] e [16]);
        int t0;
        t0 = 0;
        got.delete();
        for (int i = 0; i < n; i++) begin
            bus.rd_en = 1; bus.rd_addr = a[i];
            tick();
            if (i == 0) t0 = cyc;
        end
        bus.rd_en = 0;
        repeat (L + 1) tick();
        chk("burst_count", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk("burst_data", got[i].d, e[i]);
            chk("burst_cycle", got[i].c, t0 + L - 1 + i);
        end
    endtask

    task automatic rd1(input logic [3:0] a, input logic [31:0] e);
        logic [3:0]  aa [16];
        logic [31:0] ee [16];
        aa[0] = a; ee[0] = e;
        burst(1, aa, ee);
    endtask

    task automatic both(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] e);
        int t0;
        got.delete();
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
        bus.rd_en = 1; bus.rd_addr = a;
        tick();
        t0 = cyc;
        bus.wr_en = 0; bus.rd_en = 0;
        repeat (L + 1) tick();
        chk("rdw_count", got.size(), 1);
        if (got.size() != 0) begin
            chk("rdw_data", got[0].d, e);
            chk("rdw_cycle", got[0].c, t0 + L - 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  aa [16];
        logic [31:0] ee [16];
        int n, t0;
        bus.clear_start = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.wr_be = '0; bus.rd_en = 0; bus.rd_addr = '0;
        // power-up clear: busy for 16 cycles, then everything reads zero
        reset = 0;
        tick();
        reset = 1;
        wait_ready(n);
        chk("reset_busy_cycles", n, 16);
        for (int i = 0; i < 16; i++) begin aa[i] = 4'(i); ee[i] = '0; end
        burst(16, aa, ee);
        // byte-enable merge and all-zero enable no-op
        wr(3, 32'hDEADBEEF, 4'hF);
        wr(3, 32'h0000AA00, 4'b0010);
        rd1(3, 32'hDEADAAEF);
        wr(3, 32'h12345678, 4'h0);
        rd1(3, 32'hDEADAAEF);
        // latency and back-to-back order
        wr(5, 32'hA5A5A5A5, 4'hF);
        wr(6, 32'h01234567, 4'hF);
        wr(8, 32'h89ABCDEF, 4'hF);
        wr(9, 32'hFEDCBA98, 4'hF);
        rd1(5, 32'hA5A5A5A5);
        aa[0] = 5; aa[1] = 6; aa[2] = 8; aa[3] = 9;
        ee[0] = 32'hA5A5A5A5; ee[1] = 32'h01234567; ee[2] = 32'h89ABCDEF; ee[3] = 32'hFEDCBA98;
        burst(4, aa, ee);
        // read-during-write on the same address
        wr(7, 32'h11111111, 4'hF);
        both(7, 32'h22222222, 4'hF, WF != 0 ? 32'h22222222 : 32'h11111111);
        rd1(7, 32'h22222222);
        both(7, 32'h000000AA, 4'b0001, WF != 0 ? 32'h222222AA : 32'h22222222);
        rd1(7, 32'h222222AA);
        // clear_start alongside an accepted read and write; requests while busy are dropped
        wr(2, 32'hCAFEF00D, 4'hF);
        got.delete();
        bus.clear_start = 1; bus.rd_en = 1; bus.rd_addr = 2;
        bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'h44444444; bus.wr_be = 4'hF;
        tick();
        t0 = cyc;
        bus.clear_start = 0; bus.wr_addr = 2; bus.wr_data = 32'hFFFFFFFF;
        tick();
        bus.wr_en = 0; bus.rd_en = 0;
        wait_ready(n);
        chk("clear_busy_left", n, 15);
        chk("clear_rd_count", got.size(), 1);
        if (got.size() != 0) begin
            chk("clear_rd_data", got[0].d, 32'hCAFEF00D);
            chk("clear_rd_cycle", got[0].c, t0 + L - 1);
        end
        for (int i = 0; i < 16; i++) begin aa[i] = 4'(i); ee[i] = '0; end
        burst(16, aa, ee);
        // reset part-way through a clear restarts it from word 0
        bus.clear_start = 1;
        tick();
        bus.clear_start = 0;
        repeat (9) tick();
        reset = 0;
        tick();
        reset = 1;
        wait_ready(n);
        chk("midclear_reset_busy", n, 16);
        // reset with a read in flight produces no response
        wr(1, 32'h01010101, 4'hF);
        got.delete();
        bus.rd_en = 1; bus.rd_addr = 1;
        tick();
        bus.rd_en = 0;
        reset = 0;
        tick();
        reset = 1;
        wait_ready(n);
        chk("inflight_reset_busy", n, 16);
        chk("inflight_no_rsp", got.size(), 0);
        rd1(1, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
